// File: rtl/hdmi_text_pkg.sv
// Shared constants, response codes and FSM states
// for the HDMI text controller register block.
package hdmi_text_pkg;

  localparam int NUM_VRAM_WORDS = 600;
  localparam int CTRL_INDEX     = 600;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_COMMIT  = 2'd1,
    W_RESP    = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hdmi_text_axi_regs_if.sv
// AXI4-Lite channel bundle between the interconnect
// and the text controller register block.
interface hdmi_text_axi_regs_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();

  logic [AW-1:0]   axi_awaddr;
  logic [2:0]      axi_awprot;
  logic            axi_awvalid;
  logic            axi_awready;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_wvalid;
  logic            axi_wready;
  logic [1:0]      axi_bresp;
  logic            axi_bvalid;
  logic            axi_bready;
  logic [AW-1:0]   axi_araddr;
  logic [2:0]      axi_arprot;
  logic            axi_arvalid;
  logic            axi_arready;
  logic [DW-1:0]   axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_rvalid;
  logic            axi_rready;

  modport master (
    output axi_awaddr, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid,
    output axi_rready
  );

  modport slave (
    input  axi_awaddr, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid,
    input  axi_rready
  );

endinterface

// File: rtl/hdmi_text_regfile.sv
// 601x32 register array: byte-enable write, comb bus read,
// registered pixel read and a direct control-word tap.
import hdmi_text_pkg::*;

module hdmi_text_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [9:0]  widx,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [9:0]  bus_idx,
  output logic [31:0] bus_rdata,
  input  logic [9:0]  pix_idx,
  output logic [31:0] pix_rdata,
  output logic [31:0] ctrl
);

  localparam int DEPTH = CTRL_INDEX + 1;

  logic [31:0] mem [DEPTH];

  // storage: clear on reset, merge enabled byte lanes on write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= merge_bytes(mem[widx], wdata, wstrb);
    end
  end

  assign bus_rdata = (bus_idx < 10'(DEPTH)) ? mem[bus_idx] : '0;

  // pixel port sees pre-edge contents, so it returns old data on a same-edge write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_rdata <= '0;
    end else if (pix_idx < 10'(NUM_VRAM_WORDS)) begin
      pix_rdata <= mem[pix_idx];
    end else begin
      pix_rdata <= '0;
    end
  end

  assign ctrl = mem[CTRL_INDEX];

endmodule

// File: rtl/hdmi_text_axi_regs.sv
// AXI4-Lite responder for the HDMI text VRAM and control
// register, with a registered pixel-side read port.
import hdmi_text_pkg::*;

module hdmi_text_axi_regs #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int NUM_REGS         = 601
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  hdmi_text_axi_regs_if.slave         axi,
  input  logic [9:0]                  vram_raddr,
  output logic [31:0]                 vram_rdata,
  output logic [31:0]                 ctrl_reg
);

  localparam int IW = C_AXI_ADDR_WIDTH - 2;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  wstate_t                     wstate;
  logic                        aw_held;
  logic                        w_held;
  logic [IW-1:0]               aw_idx;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]               wstrb_q;
  logic                        bvalid;
  logic [1:0]                  bresp;

  rstate_t                     rstate;
  logic                        rvalid;
  logic [1:0]                  rresp;
  logic [C_AXI_DATA_WIDTH-1:0] rdata;

  logic                        aw_hs;
  logic                        w_hs;
  logic                        aw_in_range;
  logic                        reg_we;
  logic [IW-1:0]               ar_idx;
  logic                        ar_in_range;
  logic [31:0]                 bus_rdata;
  logic                        unused_bits;

  assign axi.axi_awready = !aw_held && !bvalid;
  assign axi.axi_wready  = !w_held && !bvalid;
  assign axi.axi_bvalid  = bvalid;
  assign axi.axi_bresp   = bresp;

  assign aw_hs = axi.axi_awvalid && axi.axi_awready;
  assign w_hs  = axi.axi_wvalid && axi.axi_wready;

  assign aw_in_range = aw_idx < IW'(NUM_REGS);
  assign reg_we      = (wstate == W_COMMIT) && aw_in_range;

  // write side: collect AW and W in any order, commit, then hold the response
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wstate  <= W_COLLECT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_idx  <= axi.axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
        aw_held <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= axi.axi_wdata;
        wstrb_q <= axi.axi_wstrb;
        w_held  <= 1'b1;
      end
      unique case (wstate)
        W_COLLECT: begin
          if ((aw_held || aw_hs) && (w_held || w_hs))
            wstate <= W_COMMIT;
        end
        W_COMMIT: begin
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          bvalid  <= 1'b1;
          bresp   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
          wstate  <= W_RESP;
        end
        W_RESP: begin
          if (axi.axi_bready) begin
            bvalid <= 1'b0;
            wstate <= W_COLLECT;
          end
        end
        default: wstate <= W_COLLECT;
      endcase
    end
  end

  assign ar_idx      = axi.axi_araddr[C_AXI_ADDR_WIDTH-1:2];
  assign ar_in_range = ar_idx < IW'(NUM_REGS);

  assign axi.axi_arready = (rstate == R_IDLE);
  assign axi.axi_rvalid  = rvalid;
  assign axi.axi_rresp   = rresp;
  assign axi.axi_rdata   = rdata;

  // read side: capture on AR handshake, hold until the master takes it
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rstate <= R_IDLE;
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (axi.axi_arvalid) begin
            rdata  <= ar_in_range ? bus_rdata : '0;
            rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid <= 1'b1;
            rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi.axi_rready) begin
            rvalid <= 1'b0;
            rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  hdmi_text_regfile u_regfile (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .we        (reg_we),
    .widx      (10'(aw_idx)),
    .wdata     (wdata_q),
    .wstrb     (wstrb_q),
    .bus_idx   (10'(ar_idx)),
    .bus_rdata (bus_rdata),
    .pix_idx   (vram_raddr),
    .pix_rdata (vram_rdata),
    .ctrl      (ctrl_reg)
  );

  assign unused_bits = ^{axi.axi_awprot, axi.axi_arprot,
                         axi.axi_awaddr[1:0], axi.axi_araddr[1:0]};

endmodule

// File: tb/tb_hdmi_text_axi_regs.sv
// Randomized self-checking bench for hdmi_text_axi_regs
// against an array-based register model.
module tb_hdmi_text_axi_regs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hdmi_text_axi_regs_if #(.AW(16), .DW(32)) axi ();

  logic [9:0]  vram_raddr;
  logic [31:0] vram_rdata;
  logic [31:0] ctrl_reg;

  hdmi_text_axi_regs dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .axi         (axi),
    .vram_raddr  (vram_raddr),
    .vram_rdata  (vram_rdata),
    .ctrl_reg    (ctrl_reg)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] model [0:600];

  function automatic logic [31:0] strb_apply(
    input logic [31:0] old_w, input logic [31:0] d,
    input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_w & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] exp_data(input int idx);
    return (idx <= 600) ? model[idx] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input int idx);
    return (idx <= 600) ? 2'b00 : 2'b10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i <= 600; i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly,
                          input int w_dly, output logic [1:0] resp,
                          output bit ok);
    bit aw_done, w_done, a_hs, d_hs;
    int c;
    aw_done = 0; w_done = 0; c = 0; ok = 0; resp = 2'bxx;
    axi.axi_awaddr = a; axi.axi_wdata = d; axi.axi_wstrb = s;
    while (!(aw_done && w_done) && c < 60) begin
      axi.axi_awvalid = !aw_done && (c >= aw_dly);
      axi.axi_wvalid  = !w_done && (c >= w_dly);
      a_hs = axi.axi_awvalid && axi.axi_awready;
      d_hs = axi.axi_wvalid && axi.axi_wready;
      tick();
      c++;
      if (a_hs) aw_done = 1;
      if (d_hs) w_done = 1;
    end
    axi.axi_awvalid = 0;
    axi.axi_wvalid = 0;
    if (aw_done && w_done) begin
      axi.axi_bready = 1;
      c = 0;
      while (!axi.axi_bvalid && c < 20) begin tick(); c++; end
      if (axi.axi_bvalid) begin
        resp = axi.axi_bresp;
        ok = 1;
        tick();
        if (int'(a[15:2]) <= 600)
          model[a[15:2]] = strb_apply(model[a[15:2]], d, s);
      end
      axi.axi_bready = 0;
    end
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] d,
                         output logic [1:0] r, output bit ok);
    int c;
    bit hs;
    ok = 0; d = 'x; r = 'x; hs = 0; c = 0;
    axi.axi_araddr = a; axi.axi_arvalid = 1; axi.axi_rready = 1;
    while (!hs && c < 20) begin hs = axi.axi_arready; tick(); c++; end
    axi.axi_arvalid = 0;
    c = 0;
    while (hs && !axi.axi_rvalid && c < 20) begin tick(); c++; end
    if (hs && axi.axi_rvalid) begin
      d = axi.axi_rdata;
      r = axi.axi_rresp;
      ok = 1;
      tick();
    end
    axi.axi_rready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    #1;
    total++;
    if ({axi.axi_awready, axi.axi_wready, axi.axi_arready,
         axi.axi_bvalid, axi.axi_rvalid} !== 5'b11100) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=11100",
        {axi.axi_awready, axi.axi_wready, axi.axi_arready,
         axi.axi_bvalid, axi.axi_rvalid});
    end
    total++;
    if ({axi.axi_bresp, axi.axi_rresp, axi.axi_rdata} !== 36'h0) begin
      bad++;
      $display("FAIL reset_resp_data got=%h exp=0",
        {axi.axi_bresp, axi.axi_rresp, axi.axi_rdata});
    end
    total++;
    if ({vram_rdata, ctrl_reg} !== 64'h0) begin
      bad++;
      $display("FAIL reset_pix_ctrl got=%h exp=0", {vram_rdata, ctrl_reg});
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    do_read(16'h0014, d, r, ok);
    total++;
    if (!ok || {r, d} !== 34'h0) begin
      bad++;
      $display("FAIL reset_read5 ok=%0d got=%h exp=0", ok, {r, d});
    end
  endtask

  task automatic test_aw_first();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    bit stuck;
    axi.axi_awaddr = 16'h0010;
    axi.axi_awvalid = 1;
    total++;
    if (axi.axi_awready !== 1'b1) begin
      bad++;
      $display("FAIL awfirst_awready got=%b exp=1", axi.axi_awready);
    end
    tick();
    axi.axi_awvalid = 0;
    stuck = 1;
    for (int i = 0; i < 4; i++) begin
      if (axi.axi_awready !== 1'b0 || axi.axi_bvalid !== 1'b0) stuck = 0;
      if (i < 3) tick();
    end
    total++;
    if (!stuck) begin
      bad++;
      $display("FAIL awfirst_hold got=%b%b exp=00",
        axi.axi_awready, axi.axi_bvalid);
    end
    axi.axi_wdata = 32'hDEADBEEF;
    axi.axi_wstrb = 4'hF;
    axi.axi_wvalid = 1;
    tick();
    axi.axi_wvalid = 0;
    total++;
    if (axi.axi_bvalid !== 1'b0) begin
      bad++;
      $display("FAIL awfirst_bvalid_early got=%b exp=0", axi.axi_bvalid);
    end
    tick();
    total++;
    if ({axi.axi_bvalid, axi.axi_bresp} !== 3'b100) begin
      bad++;
      $display("FAIL awfirst_bvalid got=%b exp=100",
        {axi.axi_bvalid, axi.axi_bresp});
    end
    axi.axi_bready = 1;
    tick();
    axi.axi_bready = 0;
    model[4] = 32'hDEADBEEF;
    do_read(16'h0010, d, r, ok);
    total++;
    if (!ok || {r, d} !== {2'b00, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL awfirst_readback got=%h exp=%h", {r, d},
        {2'b00, 32'hDEADBEEF});
    end
  endtask

  task automatic test_w_first_strobe();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    do_write(16'h0010, 32'h0000AB00, 4'b0010, 2, 0, r, ok);
    total++;
    if (!ok || r !== 2'b00) begin
      bad++;
      $display("FAIL wfirst_bresp ok=%0d got=%b exp=00", ok, r);
    end
    do_read(16'h0010, d, r, ok);
    total++;
    if (!ok || {r, d} !== {2'b00, 32'hDEADABEF}) begin
      bad++;
      $display("FAIL wfirst_readback got=%h exp=%h", {r, d},
        {2'b00, 32'hDEADABEF});
    end
  endtask

  task automatic test_bready_backpressure();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    bit steady;
    axi.axi_awaddr = 16'h0960;
    axi.axi_wdata = 32'h001F6000;
    axi.axi_wstrb = 4'hF;
    axi.axi_awvalid = 1;
    axi.axi_wvalid = 1;
    axi.axi_bready = 0;
    tick();
    axi.axi_awvalid = 0;
    axi.axi_wvalid = 0;
    tick();
    axi.axi_awaddr = 16'h0000;
    axi.axi_wdata = 32'h12345678;
    axi.axi_awvalid = 1;
    axi.axi_wvalid = 1;
    steady = 1;
    for (int i = 0; i < 10; i++) begin
      if ({axi.axi_bvalid, axi.axi_bresp, axi.axi_awready,
           axi.axi_wready} !== 5'b10000) steady = 0;
      tick();
    end
    total++;
    if (!steady) begin
      bad++;
      $display("FAIL bready_stall got=%b exp=10000",
        {axi.axi_bvalid, axi.axi_bresp, axi.axi_awready, axi.axi_wready});
    end
    axi.axi_awvalid = 0;
    axi.axi_wvalid = 0;
    model[600] = 32'h001F6000;
    total++;
    if (ctrl_reg !== model[600]) begin
      bad++;
      $display("FAIL bready_ctrl got=%h exp=%h", ctrl_reg, model[600]);
    end
    axi.axi_bready = 1;
    tick();
    axi.axi_bready = 0;
    total++;
    if (axi.axi_bvalid !== 1'b0) begin
      bad++;
      $display("FAIL bready_release got=%b exp=0", axi.axi_bvalid);
    end
    do_read(16'h0000, d, r, ok);
    total++;
    if (!ok || {r, d} !== {2'b00, model[0]}) begin
      bad++;
      $display("FAIL bready_noaccept got=%h exp=%h", {r, d},
        {2'b00, model[0]});
    end
  endtask

  task automatic test_rready_backpressure();
    bit steady;
    axi.axi_araddr = 16'h0010;
    axi.axi_arvalid = 1;
    axi.axi_rready = 0;
    tick();
    axi.axi_arvalid = 0;
    steady = 1;
    for (int i = 0; i < 5; i++) begin
      if ({axi.axi_rvalid, axi.axi_arready, axi.axi_rresp,
           axi.axi_rdata} !== {1'b1, 1'b0, 2'b00, model[4]}) steady = 0;
      tick();
    end
    total++;
    if (!steady) begin
      bad++;
      $display("FAIL rready_stall got=%h exp=%h",
        {axi.axi_rvalid, axi.axi_arready, axi.axi_rresp, axi.axi_rdata},
        {1'b1, 1'b0, 2'b00, model[4]});
    end
    axi.axi_rready = 1;
    tick();
    axi.axi_rready = 0;
    total++;
    if ({axi.axi_rvalid, axi.axi_arready} !== 2'b01) begin
      bad++;
      $display("FAIL rready_release got=%b exp=01",
        {axi.axi_rvalid, axi.axi_arready});
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    do_write(16'h0964, 32'hFFFFFFFF, 4'hF, 0, 1, r, ok);
    total++;
    if (!ok || r !== 2'b10) begin
      bad++;
      $display("FAIL oor_bresp ok=%0d got=%b exp=10", ok, r);
    end
    do_read(16'h0964, d, r, ok);
    total++;
    if (!ok || {r, d} !== {2'b10, 32'h0}) begin
      bad++;
      $display("FAIL oor_read got=%h exp=%h", {r, d}, {2'b10, 32'h0});
    end
    do_read(16'h0000, d, r, ok);
    total++;
    if (!ok || d !== model[0]) begin
      bad++;
      $display("FAIL oor_reg0 got=%h exp=%h", d, model[0]);
    end
    do_read(16'h095C, d, r, ok);
    total++;
    if (!ok || d !== model[599]) begin
      bad++;
      $display("FAIL oor_reg599 got=%h exp=%h", d, model[599]);
    end
  endtask

  task automatic test_collision();
    logic [31:0] old_v, new_v;
    old_v = model[3];
    new_v = old_v ^ 32'hA5A5_0F0F;
    axi.axi_awaddr = 16'h000C;
    axi.axi_wdata = new_v;
    axi.axi_wstrb = 4'hF;
    axi.axi_awvalid = 1;
    axi.axi_wvalid = 1;
    axi.axi_bready = 0;
    tick();
    axi.axi_awvalid = 0;
    axi.axi_wvalid = 0;
    axi.axi_araddr = 16'h000C;
    axi.axi_arvalid = 1;
    axi.axi_rready = 0;
    vram_raddr = 10'd3;
    tick();
    axi.axi_arvalid = 0;
    total++;
    if ({axi.axi_rvalid, axi.axi_rdata} !== {1'b1, old_v}) begin
      bad++;
      $display("FAIL coll_bus got=%h exp=%h",
        {axi.axi_rvalid, axi.axi_rdata}, {1'b1, old_v});
    end
    total++;
    if (vram_rdata !== old_v) begin
      bad++;
      $display("FAIL coll_pix_old got=%h exp=%h", vram_rdata, old_v);
    end
    tick();
    total++;
    if (vram_rdata !== new_v) begin
      bad++;
      $display("FAIL coll_pix_new got=%h exp=%h", vram_rdata, new_v);
    end
    axi.axi_rready = 1;
    axi.axi_bready = 1;
    tick();
    axi.axi_rready = 0;
    axi.axi_bready = 0;
    model[3] = new_v;
  endtask

  task automatic test_random();
    logic [31:0] d, got;
    logic [1:0] r;
    logic [3:0] s;
    bit ok;
    int idx;
    for (int n = 0; n < 40; n++) begin
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(597, 602))
                                        : int'($urandom_range(0, 15));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      do_write(16'(idx * 4), d, s, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), r, ok);
      total++;
      if (!ok || r !== exp_resp(idx)) begin
        bad++;
        $display("FAIL rand_bresp idx=%0d got=%b exp=%b", idx, r,
          exp_resp(idx));
      end
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(597, 602))
                                        : int'($urandom_range(0, 15));
      do_read(16'(idx * 4), got, r, ok);
      total++;
      if (!ok || {r, got} !== {exp_resp(idx), exp_data(idx)}) begin
        bad++;
        $display("FAIL rand_read idx=%0d got=%h exp=%h", idx, {r, got},
          {exp_resp(idx), exp_data(idx)});
      end
      vram_raddr = 10'(idx);
      tick();
      total++;
      if (vram_rdata !== ((idx < 600) ? model[idx] : 32'h0)) begin
        bad++;
        $display("FAIL rand_pix idx=%0d got=%h exp=%h", idx, vram_rdata,
          (idx < 600) ? model[idx] : 32'h0);
      end
      total++;
      if (ctrl_reg !== model[600]) begin
        bad++;
        $display("FAIL rand_ctrl got=%h exp=%h", ctrl_reg, model[600]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    bit quiet;
    axi.axi_awaddr = 16'h0010;
    axi.axi_awvalid = 1;
    tick();
    axi.axi_awvalid = 0;
    #2;
    rst_n = 0;
    #1;
    total++;
    if ({axi.axi_awready, axi.axi_bvalid, ctrl_reg} !== {2'b10, 32'h0}) begin
      bad++;
      $display("FAIL arst_state got=%h exp=%h",
        {axi.axi_awready, axi.axi_bvalid, ctrl_reg}, {2'b10, 32'h0});
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    clear_model();
    axi.axi_wdata = 32'hCAFE_F00D;
    axi.axi_wstrb = 4'hF;
    axi.axi_wvalid = 1;
    tick();
    axi.axi_wvalid = 0;
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      if (axi.axi_bvalid !== 1'b0) quiet = 0;
      tick();
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL arst_discard got=%b exp=0", axi.axi_bvalid);
    end
    axi.axi_awaddr = 16'h0020;
    axi.axi_awvalid = 1;
    tick();
    axi.axi_awvalid = 0;
    tick();
    total++;
    if (axi.axi_bvalid !== 1'b1) begin
      bad++;
      $display("FAIL arst_complete got=%b exp=1", axi.axi_bvalid);
    end
    axi.axi_bready = 1;
    tick();
    axi.axi_bready = 0;
    model[8] = 32'hCAFE_F00D;
    do_read(16'h0010, d, r, ok);
    total++;
    if (!ok || d !== 32'h0) begin
      bad++;
      $display("FAIL arst_cleared got=%h exp=0", d);
    end
    do_read(16'h0020, d, r, ok);
    total++;
    if (!ok || d !== model[8]) begin
      bad++;
      $display("FAIL arst_newwrite got=%h exp=%h", d, model[8]);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    for (int i = 0; i < 600; i++) begin
      do_write(16'(i * 4), 32'(i), 4'hF, 0, 0, r, ok);
      total++;
      if (!ok || r !== 2'b00) begin
        bad++;
        $display("FAIL sweep_wr i=%0d got=%b exp=00", i, r);
      end
    end
    for (int i = 0; i < 600; i++) begin
      do_read(16'(i * 4), d, r, ok);
      total++;
      if (!ok || {r, d} !== {2'b00, model[i]}) begin
        bad++;
        $display("FAIL sweep_rd i=%0d got=%h exp=%h", i, {r, d},
          {2'b00, model[i]});
      end
    end
    vram_raddr = 10'd599;
    tick();
    total++;
    if (vram_rdata !== 32'd599) begin
      bad++;
      $display("FAIL sweep_pix599 got=%h exp=%h", vram_rdata, 32'd599);
    end
    vram_raddr = 10'd600;
    tick();
    total++;
    if (vram_rdata !== 32'h0) begin
      bad++;
      $display("FAIL sweep_pix600 got=%h exp=0", vram_rdata);
    end
  endtask

  initial begin
    axi.axi_awaddr = '0; axi.axi_awprot = '0; axi.axi_awvalid = 0;
    axi.axi_wdata = '0; axi.axi_wstrb = '0; axi.axi_wvalid = 0;
    axi.axi_bready = 0;
    axi.axi_araddr = '0; axi.axi_arprot = '0; axi.axi_arvalid = 0;
    axi.axi_rready = 0;
    vram_raddr = '0;
    clear_model();
    test_reset();
    test_aw_first();
    test_w_first_strobe();
    test_bready_backpressure();
    test_rready_backpressure();
    test_out_of_range();
    test_collision();
    test_random();
    test_async_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_text_axi_regs.md
# hdmi_text_axi_regs

AXI4-Lite responder that owns the HDMI text controller's register space: 600 VRAM words (80x30 characters, 4 glyphs per word) plus one control register holding the foreground/background colours. It sits between the MicroBlaze AXI interconnect and the pixel-side drawing logic. It handles independent address and data handshakes, byte strobes, and back-pressure on the response channels. It also provides a second, registered read port for the text renderer.

## Interface
- C_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 16, byte-address width; word index = addr[C_AXI_ADDR_WIDTH-1:2].
- NUM_REGS, 601, word count; indices 0..599 are VRAM, index 600 is the control register.

- axi_aclk  in  1  single clock for the bus side and the pixel-side read port.
- axi_aresetn  in  1  asynchronous, active-low reset.
- axi_awaddr / axi_awprot / axi_awvalid  in  16/3/1  write address channel; awprot is ignored.
- axi_awready  out  1
- axi_wdata / axi_wstrb / axi_wvalid  in  32/4/1  write data channel.
- axi_wready  out  1
- axi_bresp  out  2, axi_bvalid  out  1, axi_bready  in  1  write response channel.
- axi_araddr / axi_arprot / axi_arvalid  in  16/3/1  read address channel; arprot is ignored.
- axi_arready  out  1
- axi_rdata  out  32, axi_rresp  out  2, axi_rvalid  out  1, axi_rready  in  1  read data channel.
- vram_raddr  in  10  pixel-side word index.
- vram_rdata  out  32  pixel-side data, one cycle after vram_raddr.
- ctrl_reg  out  32  live copy of register 600.

## Operation
- Reset state:
  - All 601 registers are 0.
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - vram_rdata=0, ctrl_reg=0.
- Write side uses two holding flags, aw_held and w_held:
  - awready = !aw_held && !bvalid.
  - wready = !w_held && !bvalid.
  - An AW handshake (awvalid && awready at an edge) latches the address and sets aw_held.
  - A W handshake latches data and strobe and sets w_held.
  - AW and W can arrive in either order, or on the same edge.
- Write states:
  - W_COLLECT: waiting for either or both halves.
  - W_COMMIT: one cycle. Entered when both flags are set. Writes byte lanes where strb[k]=1 (lane k = bits 8k+7:8k) and leaves the other lanes unchanged. Clears both flags and sets bvalid.
  - W_RESP: hold bvalid and bresp until bvalid && bready, then return to W_COLLECT.
- Out-of-range write (index >= 601): no register changes, bresp=2'b10 (SLVERR). In-range writes return OKAY (00).
- Read states:
  - R_IDLE: arready=1. On an AR handshake, capture reg[index] into rdata, set rvalid, go to R_DATA.
  - R_DATA: arready=0. Hold rdata and rresp until rready, then return to R_IDLE.
  - Out-of-range reads return rdata=0 with rresp=SLVERR.
- Read and write channels are fully independent and may be active in the same cycle.
- Pixel port: vram_rdata <= reg[vram_raddr] on every edge. Indices >= 600 return 0.
- ctrl_reg is reg[600], driven combinationally from the flop.

## Timing
- Write latency: the last of the AW/W handshakes at edge N → register updated and bvalid=1 at edge N+1.
  - Minimum spacing between writes is 3 edges when bready is held high.
- Read latency: AR handshake at edge N → rvalid=1 with data from after edge N.
- Collision, write and read to the same address: a commit and an AR handshake on the same edge return the old value. A commit one edge earlier returns the new value.
- Collision, write and pixel port: the same rule applies (old value on the same edge).
- Back-pressure: bvalid/bresp and rvalid/rdata/rresp stay stable while ready is low, for any number of cycles.
- While bvalid=1, no new AW or W is accepted.
- Reset asserted mid-transaction: all state drops immediately (async). Any pending write is discarded and the registers clear.

## Structure
- Package hdmi_text_pkg holds:
  - NUM_VRAM_WORDS=600, CTRL_INDEX=600.
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write/read FSM state enums.
- Sub-module hdmi_text_regfile holds the 601x32 flop array with:
  - one byte-enable write port;
  - one combinational bus read port;
  - one registered pixel read port;
  - a direct ctrl tap.

## Test plan
- Reset: all outputs hold the reset values listed above; a read of index 5 returns 0 with OKAY.
- AW first, W three cycles later (addr 0x0010, data 0xDEADBEEF, strb F):
  - AW accepted, awready drops and stays low until W arrives.
  - bvalid goes high one edge after the W handshake.
  - Readback of 0x10 gives 0xDEADBEEF.
- W before AW, then strobe 4'b0010 with data 0x0000AB00 to addr 0x0010 → readback 0xDEADABEF.
- bready held low for 10 cycles after a write to 0x0960 (data 0x001F6000):
  - bvalid and bresp stay stable, and no new AW is accepted during that time;
  - ctrl_reg reads 0x001F6000 after the commit.
- rready held low for 5 cycles: rdata stays stable throughout; arready is 0 until the rready handshake.
- Out-of-range, with contents of registers 0 and 599 checked unchanged afterwards:
  - write to 0x0964 → bresp=2'b10;
  - read of 0x0964 → rdata=0, rresp=2'b10.
- Full sweep: write i to word i for i=0..599, then read all back with no mismatches; pixel port at vram_raddr=599 gives 599 one cycle later.
